conv_acc_sched: RTL and testbench
=================================

Name: conv_acc_sched

Overview:
Sequencer for the NPUCore MAC array inside ConvUnit. Per layer tile it requests a weight-buffer load, then streams input beats into the array. It drives the weight-set select, the accumulator clear (adder_rst) and the MAC valid strobe, and tags the final accumulation of each output pixel so that MAC_data_valid_out lines up with the MAC pipeline latency.

Parameters:
ACC_W, 8, width of accumulate-count config and weight_sel
PIX_W, 16, width of output-pixel count config
MAC_LAT, 4, cycles from mac_data_valid to the accumulator result being available (MULT_PIPELINE_STAGE + 2); range 1..15

Ports:
clk  in  1  clock
rstn  in  1  async active-low reset
cfg_start  in  1  one-cycle pulse; latch cfg_* and begin tile
cfg_acc_num  in  ACC_W  input-channel tiles accumulated per output pixel
cfg_pix_num  in  PIX_W  output pixels in this tile
abort  in  1  synchronous abort, returns to IDLE
weight_req  out  1  one-cycle pulse: load weight buffer
weight_ack  in  1  weight buffer loaded (level or pulse)
data_valid_in  in  1  line-buffer beat valid
data_ready_out  out  1  controller accepts beat (combinational from state)
mac_data_valid  out  1  to NPUCore MAC_data_valid_in
weight_sel  out  ACC_W  weight-set index for the current beat
adder_rst  out  1  clear accumulator; coincides with first beat of each pixel
mac_out_valid  out  1  final accumulated result of a pixel is valid
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of tile
perf_stall_cnt  out  32  see Optional Feature

Behaviour:
- Reset: state IDLE. weight_req, mac_data_valid, adder_rst, mac_out_valid, done, busy, data_ready_out = 0; weight_sel = 0; counters and delay line cleared. Reset mid-tile discards the tile.
- Config latch on cfg_start in IDLE: acc_num = (cfg_acc_num == 0) ? 1 : cfg_acc_num; pix_num = cfg_pix_num. cfg_start while busy is ignored.
- IDLE -> WREQ on cfg_start. If pix_num == 0, go IDLE -> DONE directly with no weight_req.
- WREQ: weight_req = 1 for exactly one cycle, then -> WWAIT.
- WWAIT: stay until weight_ack = 1, then -> RUN. acc_cnt = 0, pix_cnt = 0.
- RUN:
  - data_ready_out = 1; beat accepted = data_valid_in & data_ready_out.
  - On an accepted beat, outputs registered, 1-cycle latency:
    - mac_data_valid = 1
    - weight_sel = acc_cnt
    - adder_rst = (acc_cnt == 0)
    - last = (acc_cnt == acc_num - 1)
  - acc_cnt increments and wraps to 0 on last; pix_cnt increments on last.
  - Last beat of last pixel -> DRAIN.
  - No accepted beat: mac_data_valid = 0, adder_rst = 0, weight_sel holds.
- DRAIN: data_ready_out = 0; count MAC_LAT cycles, then -> DONE.
- DONE: done = 1 for one cycle -> IDLE. busy = 1 in every state except IDLE.
- mac_out_valid: the registered "last" flag delayed MAC_LAT cycles through a shift register; it fires exactly pix_num times per tile.
- abort (any state except IDLE): next cycle IDLE. Registered strobes and the delay line are cleared; done is not pulsed. abort has priority over every other transition.
- Counter widths equal the config widths. acc_num = 2^ACC_W - 1 is legal; no overflow because the counter wraps at acc_num - 1.

Optional Feature:
CONV_ACC_SCHED_PERF_CNT_EN:
- Defined: perf_stall_cnt counts cycles in RUN with data_valid_in == 0. Cleared on cfg_start accept, saturates at 2^32-1, holds after done.
- Undefined: no counter logic; perf_stall_cnt is tied to 0.

Test Plan:
- acc_num=3, pix_num=2, weight_ack 2 cycles after weight_req, continuous valid -> weight_sel 0,1,2,0,1,2; adder_rst on beats 1 and 4; mac_out_valid exactly MAC_LAT cycles after beats 3 and 6; done once.
- Same config, data_valid_in toggling 1,0,1,0 -> strobes only on accepted beats; mac_out_valid count = 2; with macro, perf_stall_cnt = 5.
- cfg_acc_num=0, pix_num=4 -> treated as 1; adder_rst and mac_out_valid on every beat; 4 results.
- cfg_pix_num=0 -> no weight_req, no mac_data_valid; done pulse 2 cycles after cfg_start.
- abort asserted mid-RUN after 2 beats -> IDLE next cycle, no further mac_out_valid, no done; a new cfg_start then runs normally.
- rstn low for 1 cycle mid-DRAIN -> all outputs 0 immediately (async); second cfg_start during busy ignored.

Source files
------------

// File: rtl/conv_acc_sched.sv
// conv_acc_sched: weight-load / beat sequencer driving the NPUCore MAC array of ConvUnit.
// Ports: cfg_start/cfg_acc_num/cfg_pix_num start a tile; abort returns to idle;
//   weight_req/weight_ack handshake the weight buffer; data_valid_in/data_ready_out accept beats;
//   mac_data_valid/weight_sel/adder_rst drive the MAC array; mac_out_valid tags final pixel results;
//   busy/done report tile status; perf_stall_cnt counts RUN stall cycles.
// Optional: define CONV_ACC_SCHED_PERF_CNT_EN to build the stall counter (else tied to 0).
module conv_acc_sched #(
  parameter int ACC_W   = 8,
  parameter int PIX_W   = 16,
  parameter int MAC_LAT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_start,
  input  logic [ACC_W-1:0] cfg_acc_num,
  input  logic [PIX_W-1:0] cfg_pix_num,
  input  logic             abort,
  output logic             weight_req,
  input  logic             weight_ack,
  input  logic             data_valid_in,
  output logic             data_ready_out,
  output logic             mac_data_valid,
  output logic [ACC_W-1:0] weight_sel,
  output logic             adder_rst,
  output logic             mac_out_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      perf_stall_cnt
);
  typedef enum logic [2:0] {IDLE, WREQ, WWAIT, RUN, DRAIN, DONE} state_t;
  state_t state_q;
  logic [ACC_W-1:0] acc_num_q, acc_cnt_q, wsel_q;
  logic [PIX_W-1:0] pix_num_q, pix_cnt_q;
  logic [3:0] drn_q;
  logic [MAC_LAT-1:0] dl_q;
  logic wreq_q, mvalid_q, arst_q, last_q, done_q;
  logic beat, acc_last, pix_last;
  assign data_ready_out = state_q == RUN;
  assign busy = state_q != IDLE;
  assign beat = data_ready_out & data_valid_in;
  assign acc_last = acc_cnt_q == acc_num_q - 1'b1;
  assign pix_last = pix_cnt_q == pix_num_q - 1'b1;
  assign weight_req = wreq_q;
  assign mac_data_valid = mvalid_q;
  assign weight_sel = wsel_q;
  assign adder_rst = arst_q;
  assign done = done_q;
  // the "last" tag rides a shift register so it emerges with the MAC pipeline result
  assign mac_out_valid = dl_q[MAC_LAT-1];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      acc_num_q <= '0;
      pix_num_q <= '0;
      acc_cnt_q <= '0;
      pix_cnt_q <= '0;
      drn_q     <= '0;
      dl_q      <= '0;
      wsel_q    <= '0;
      wreq_q    <= 1'b0;
      mvalid_q  <= 1'b0;
      arst_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wreq_q   <= 1'b0;
      done_q   <= 1'b0;
      mvalid_q <= beat;
      arst_q   <= beat & (acc_cnt_q == '0);
      last_q   <= beat & acc_last;
      if (beat) wsel_q <= acc_cnt_q;
      dl_q <= (dl_q << 1) | MAC_LAT'(last_q);
      if (abort && state_q != IDLE) begin
        state_q  <= IDLE;
        mvalid_q <= 1'b0;
        arst_q   <= 1'b0;
        last_q   <= 1'b0;
        dl_q     <= '0;
      end else begin
        case (state_q)
          IDLE: if (cfg_start) begin
            acc_num_q <= cfg_acc_num == '0 ? ACC_W'(1) : cfg_acc_num;
            pix_num_q <= cfg_pix_num;
            state_q   <= cfg_pix_num == '0 ? DONE : WREQ;
            wreq_q    <= cfg_pix_num != '0;
          end
          WREQ: state_q <= WWAIT;
          WWAIT: if (weight_ack) begin
            state_q   <= RUN;
            acc_cnt_q <= '0;
            pix_cnt_q <= '0;
          end
          RUN: if (beat) begin
            acc_cnt_q <= acc_last ? '0 : acc_cnt_q + 1'b1;
            if (acc_last) pix_cnt_q <= pix_cnt_q + 1'b1;
            if (acc_last && pix_last) begin
              state_q <= DRAIN;
              drn_q   <= '0;
            end
          end
          DRAIN: begin
            drn_q <= drn_q + 1'b1;
            if (drn_q == 4'(MAC_LAT - 1)) state_q <= DONE;
          end
          DONE: begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
`ifdef CONV_ACC_SCHED_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= '0;
    else if (state_q == IDLE && cfg_start) perf_q <= '0;
    else if (state_q == RUN && !data_valid_in && perf_q != '1) perf_q <= perf_q + 1'b1;
  end
  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_conv_acc_sched.sv
// tb_conv_acc_sched: randomized scoreboard bench for conv_acc_sched.
module tb_conv_acc_sched;
  localparam int ACC_W = 8;
  localparam int PIX_W = 16;
  localparam int L = 4;
  logic clk = 0, rstn = 0, cfg_start = 0, abort = 0, weight_ack = 0, data_valid_in = 0;
  logic [ACC_W-1:0] cfg_acc_num = '0;
  logic [PIX_W-1:0] cfg_pix_num = '0;
  logic weight_req, data_ready_out, mac_data_valid, adder_rst, mac_out_valid, busy, done;
  logic [ACC_W-1:0] weight_sel;
  logic [31:0] perf_stall_cnt;
  conv_acc_sched #(.ACC_W(ACC_W), .PIX_W(PIX_W), .MAC_LAT(L)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_acc_num(cfg_acc_num),
    .cfg_pix_num(cfg_pix_num), .abort(abort), .weight_req(weight_req), .weight_ack(weight_ack),
    .data_valid_in(data_valid_in), .data_ready_out(data_ready_out), .mac_data_valid(mac_data_valid),
    .weight_sel(weight_sel), .adder_rst(adder_rst), .mac_out_valid(mac_out_valid), .busy(busy),
    .done(done), .perf_stall_cnt(perf_stall_cnt));
  always #5 clk = ~clk;
  typedef struct {int t; int ws; bit ar;} exp_t;
  exp_t bq[$];
  int oq[$];
  int cyc = 0, n_cmp = 0, n_bad = 0, n_done = 0, done_cyc = -1, n_wreq = 0, n_out = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rstn) begin
      if (mac_data_valid) begin
        if (bq.size() == 0) chk("unexpected_mac_valid", 1, 0);
        else begin
          exp_t e;
          e = bq.pop_front();
          chk("mac_valid_time", cyc, e.t);
          chk("weight_sel", weight_sel, e.ws);
          chk("adder_rst", adder_rst, e.ar);
        end
      end else if (adder_rst) chk("stray_adder_rst", 1, 0);
      if (mac_out_valid) begin
        n_out++;
        if (oq.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("out_valid_time", cyc, oq.pop_front());
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (weight_req) n_wreq++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // mode: 0 continuous valid, 1 alternating 1/0, 2 random
  task automatic run_tile(input int acc_cfg, input int pix, input int mode, input int abort_after,
                          input bit rst_drain, input bit busy_start);
    int acc, n, k, i, stalls, c0, d0, w0, o0, g;
    bit v;
    acc = acc_cfg == 0 ? 1 : acc_cfg;
    n = acc * pix;
    d0 = n_done; w0 = n_wreq; o0 = n_out;
    cfg_acc_num = ACC_W'(acc_cfg);
    cfg_pix_num = PIX_W'(pix);
    cfg_start = 1;
    c0 = cyc;
    tick();
    cfg_start = 0;
    cfg_acc_num = ACC_W'($urandom);
    cfg_pix_num = PIX_W'($urandom);
    if (pix == 0) begin
      g = 0;
      while (n_done == d0 && g < 10) begin tick(); g++; end
      chk("pix0_done_count", n_done - d0, 1);
      chk("pix0_done_time", done_cyc, c0 + 2);
      chk("pix0_no_weight_req", n_wreq - w0, 0);
      return;
    end
    g = 0;
    while (!weight_req && g < 20) begin tick(); g++; end
    chk("weight_req_seen", weight_req, 1);
    tick(); tick();
    weight_ack = 1;
    tick();
    weight_ack = 0;
    chk("run_entry", data_ready_out, 1);
    k = 0; i = 0; stalls = 0;
    while (k < n && i < 20000) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (i % 2 == 0) : 1'($urandom);
      cfg_start = busy_start && i == 1;
      cfg_pix_num = '0;
      data_valid_in = v;
      if (v) begin
        bq.push_back('{cyc + 1, k % acc, (k % acc) == 0});
        if (k % acc == acc - 1) oq.push_back(cyc + 1 + L);
        k++;
      end else stalls++;
      tick();
      i++;
      if (abort_after != 0 && k == abort_after) break;
    end
    data_valid_in = 0;
    cfg_start = 0;
    if (abort_after != 0) begin
      abort = 1;
      oq.delete();
      tick();
      abort = 0;
      chk("abort_busy", busy, 0);
      repeat (L + 4) tick();
      chk("abort_no_done", n_done - d0, 0);
      return;
    end
    if (rst_drain) begin
      @(negedge clk);
      #1;
      rstn = 0;
      #1;
      chk("rst_drain_outputs", {weight_req, data_ready_out, mac_data_valid, adder_rst, mac_out_valid,
                                busy, done, weight_sel, perf_stall_cnt}, 0);
      oq.delete();
      tick();
      rstn = 1;
      repeat (L + 4) tick();
      chk("rst_no_done", n_done - d0, 0);
      return;
    end
    g = 0;
    while (n_done == d0 && g < 200) begin tick(); g++; end
    tick();
    chk("done_count", n_done - d0, 1);
    chk("weight_req_count", n_wreq - w0, 1);
    chk("out_valid_count", n_out - o0, pix);
    chk("pending_beats", bq.size(), 0);
    chk("pending_outs", oq.size(), 0);
    chk("idle_busy", busy, 0);
`ifdef CONV_ACC_SCHED_PERF_CNT_EN
    chk("perf_stall_cnt", perf_stall_cnt, stalls);
`else
    chk("perf_stall_cnt_tied", perf_stall_cnt, 0);
`endif
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_outputs", {weight_req, data_ready_out, mac_data_valid, adder_rst, mac_out_valid,
                          busy, done, weight_sel, perf_stall_cnt}, 0);
    rstn = 1;
    tick();
    chk("post_reset_outputs", {weight_req, data_ready_out, mac_data_valid, adder_rst, mac_out_valid,
                               busy, done, weight_sel, perf_stall_cnt}, 0);
    run_tile(3, 2, 0, 0, 0, 0);
    run_tile(3, 2, 1, 0, 0, 0);
    run_tile(0, 4, 0, 0, 0, 0);
    run_tile(5, 0, 0, 0, 0, 0);
    run_tile(2, 3, 2, 2, 0, 0);
    run_tile(3, 2, 0, 0, 0, 0);
    run_tile(3, 2, 0, 0, 1, 0);
    run_tile(4, 3, 2, 0, 0, 1);
    for (int t = 0; t < 6; t++) run_tile(int'($urandom_range(0, 6)), int'($urandom_range(1, 5)), 2, 0, 0, 0);
    run_tile(255, 1, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
